// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, branch redirect, and IF/ID handshake to decode.
interface instruction_fetch_stage_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_data, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_data, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// LEGv8 fetch stage: owns the PC, drives instruction memory, fills the IF/ID register
// and hands it to decode over valid/ready; redirects squash the slot and reload the PC.
module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] MEM_BYTES = 64'd40,
  parameter int          CNT_W     = 32
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  instruction_fetch_stage_if.master fif,
  output logic                  halted,
  output logic                  misalign_fault,
  output logic [CNT_W-1:0]      fetch_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ifid_t;

  logic [63:0] pc;
  ifid_t       ifid;
  logic        ifid_vld;
  logic        fire;

  assign halted        = (pc >= MEM_BYTES);
  // Slot is free, or its occupant leaves this cycle, so a new capture can land.
  assign fire          = !halted && (!ifid_vld || fif.id_ready);

  assign fif.imem_addr = pc;
  assign fif.if_valid  = ifid_vld;
  assign fif.if_instr  = ifid.instr;
  assign fif.if_pc     = ifid.pc;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pc             <= RESET_PC;
      ifid           <= '0;
      ifid_vld       <= 1'b0;
      misalign_fault <= 1'b0;
      fetch_count    <= '0;
    end else if (fif.redirect_valid) begin
      // Wrong-path instruction is dropped even if decode is stalled on it.
      pc             <= {fif.redirect_target[63:2], 2'b00};
      ifid_vld       <= 1'b0;
      misalign_fault <= misalign_fault | (fif.redirect_target[1:0] != 2'b00);
    end else if (fire) begin
      ifid.instr <= fif.imem_data;
      ifid.pc    <= pc;
      ifid_vld   <= 1'b1;
      pc         <= pc + 64'd4;
      if (fetch_count != '1)
        fetch_count <= fetch_count + CNT_W'(1);
    end else if (halted && fif.id_ready) begin
      ifid_vld <= 1'b0;
    end
  end

endmodule
